// File: rtl/selftest_runner_pkg.sv
// Shared definitions for the self-test sequencer: curve prime, FSM encoding
// and the result-word packing helper.
package selftest_runner_pkg;

  // 2^255 - 19
  localparam logic [254:0] P25519 = {{250{1'b1}}, 5'b01101};

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_NEXT  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Result word idx of width w lives at bits [idx*w +: w].
  function automatic int word_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/selftest_runner_if.sv
// Request/result handshake between the self-test sequencer (master) and the
// arithmetic core under test (slave).
interface selftest_runner_if #(
  parameter int unsigned DW = 510
);
  logic          dut_req_valid;
  logic          dut_req_ready;
  logic          dut_res_valid;
  logic          dut_res_ready;
  logic [DW-1:0] dut_res;

  modport master (
    output dut_req_valid, dut_res_ready,
    input  dut_req_ready, dut_res_valid, dut_res
  );

  modport slave (
    input  dut_req_valid, dut_res_ready,
    output dut_req_ready, dut_res_valid, dut_res
  );
endinterface

// File: rtl/selftest_runner_timeout_ctr.sv
// Watchdog timer for one outstanding DUT request; o_expired flags the last
// allowed cycle so the caller can abort on the same edge.
module selftest_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16777216
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && (r_count == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/selftest_runner.sv
// On-chip self-test sequencer: issues N_VEC requests to an arithmetic core,
// compares each result against the external vector ROM and tallies verdicts.
module selftest_runner
  import selftest_runner_pkg::*;
#(
  parameter int unsigned W       = 255,
  parameter int unsigned NOUT    = 2,
  parameter int unsigned N_VEC   = 4,
  parameter int unsigned TIMEOUT = 16777216,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 loop_mode,
  output logic [7:0]           vec_idx,
  input  logic [NOUT*W-1:0]    exp_data,
  selftest_runner_if.master    dut_if,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_flag,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [7:0]           last_fail_idx
);

  localparam logic [7:0] LAST_IDX = 8'(N_VEC - 1);

  state_t          r_state;
  logic [7:0]      r_vec_idx;
  logic [7:0]      r_last_fail;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic            r_loop;
  logic            r_timeout;
  logic            r_match;

  logic            w_expired;
  logic [NOUT-1:0] w_word_eq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_word_eq = '0;
    for (int i = 0; i < NOUT; i++) begin
      w_word_eq[i] = (dut_if.dut_res[word_lsb(i, W) +: W] == exp_data[word_lsb(i, W) +: W]);
    end
  end

  selftest_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != ST_WAIT),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vec_idx   <= '0;
      r_last_fail <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_loop      <= 1'b0;
      r_timeout   <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_vec_idx   <= '0;
            r_last_fail <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_timeout   <= 1'b0;
            r_loop      <= loop_mode;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dut_if.dut_req_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the final timer cycle still counts.
          if (dut_if.dut_res_valid) begin
            r_match <= &w_word_eq;
            r_state <= ST_CHECK;
          end else if (w_expired) begin
            r_fail      <= sat_inc(r_fail);
            r_last_fail <= r_vec_idx;
            r_timeout   <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_CHECK: begin
          if (r_match) begin
            r_pass <= sat_inc(r_pass);
          end else begin
            r_fail      <= sat_inc(r_fail);
            r_last_fail <= r_vec_idx;
          end
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_vec_idx != LAST_IDX) begin
            r_vec_idx <= r_vec_idx + 8'd1;
            r_state   <= ST_ISSUE;
          end else if (r_loop) begin
            r_vec_idx <= '0;
            r_state   <= ST_ISSUE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dut_if.dut_req_valid = (r_state == ST_ISSUE);
  assign dut_if.dut_res_ready = (r_state == ST_WAIT);

  assign busy          = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                         (r_state == ST_CHECK) || (r_state == ST_NEXT);
  assign done          = (r_state == ST_DONE);
  assign vec_idx       = r_vec_idx;
  assign timeout_flag  = r_timeout;
  assign pass_count    = r_pass;
  assign fail_count    = r_fail;
  assign last_fail_idx = r_last_fail;

endmodule

// File: tb/tb_selftest_runner.sv
// Bench for selftest_runner: behavioural mock DUT and vector ROM, scoreboard of
// per-vector verdicts, directed scenarios for timing, faults, timeout and looping.
module tb_selftest_runner;
  import selftest_runner_pkg::*;

  localparam int W       = 255;
  localparam int NOUT    = 2;
  localparam int N_VEC   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int LAT     = 3;
  localparam int DW      = NOUT * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             loop_mode;
  logic [7:0]       vec_idx;
  logic [DW-1:0]    exp_data;
  logic             busy;
  logic             done;
  logic             timeout_flag;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [7:0]       last_fail_idx;

  int n_cmp = 0;
  int n_mis = 0;

  selftest_runner_if #(.DW(DW)) dut_if ();

  selftest_runner #(
    .W(W), .NOUT(NOUT), .N_VEC(N_VEC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .loop_mode     (loop_mode),
    .vec_idx       (vec_idx),
    .exp_data      (exp_data),
    .dut_if        (dut_if.master),
    .busy          (busy),
    .done          (done),
    .timeout_flag  (timeout_flag),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .last_fail_idx (last_fail_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Vector ROM: word i of vector idx is P25519 - (idx*NOUT + i + 1).
  function automatic logic [DW-1:0] rom(input logic [7:0] idx);
    logic [DW-1:0] r;
    for (int i = 0; i < NOUT; i++) r[i*W +: W] = P25519 - 255'(int'(idx) * NOUT + i + 1);
    return r;
  endfunction

  assign exp_data = rom(vec_idx);

  // Mock arithmetic core
  logic       req_ready_en;
  int         hang_idx;
  int         corrupt_idx;
  logic       mock_busy;
  int         mock_cnt;
  logic [7:0] mock_idx;

  assign dut_if.dut_req_ready = req_ready_en && !mock_busy;

  always @(posedge clk) begin
    if (rst) begin
      mock_busy            <= 1'b0;
      mock_cnt             <= 0;
      mock_idx             <= '0;
      dut_if.dut_res_valid <= 1'b0;
      dut_if.dut_res       <= '0;
    end else if (!mock_busy) begin
      if (dut_if.dut_req_valid && dut_if.dut_req_ready) begin
        mock_busy <= 1'b1;
        mock_cnt  <= 0;
        mock_idx  <= vec_idx;
      end
    end else if (dut_if.dut_res_valid) begin
      if (dut_if.dut_res_ready) begin
        dut_if.dut_res_valid <= 1'b0;
        mock_busy            <= 1'b0;
      end
    end else if (int'(mock_idx) != hang_idx) begin
      mock_cnt <= mock_cnt + 1;
      if (mock_cnt == LAT - 1) begin
        logic [DW-1:0] res;
        res = rom(mock_idx);
        if (int'(mock_idx) == corrupt_idx) res[W] = ~res[W];
        dut_if.dut_res_valid <= 1'b1;
        dut_if.dut_res       <= res;
      end
    end
  end

  // Scoreboard: verdict pushed at each result handshake, compared once CHECK has updated the counters.
  typedef struct {
    logic       pass;
    logic [7:0] idx;
  } sb_t;

  sb_t sb_q[$];
  int  sb_due   = 0;
  int  exp_pass = 0;
  int  exp_fail = 0;
  int  exp_last = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb_due = 0;
      sb_q.delete();
      exp_pass = 0;
      exp_fail = 0;
      exp_last = 0;
    end else begin
      if (start && !busy) begin
        exp_pass = 0;
        exp_fail = 0;
        exp_last = 0;
      end
      if (sb_due > 0) begin
        sb_due--;
        if (sb_due == 0) begin
          if (sb_q.size() == 0) begin
            check("sb_queue_nonempty", 0, 1);
          end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.pass) begin
              if (exp_pass < (1 << CNT_W) - 1) exp_pass++;
            end else begin
              if (exp_fail < (1 << CNT_W) - 1) exp_fail++;
              exp_last = int'(e.idx);
            end
            check("sb_pass_count", 32'(pass_count), exp_pass);
            check("sb_fail_count", 32'(fail_count), exp_fail);
            check("sb_last_fail_idx", 32'(last_fail_idx), exp_last);
          end
        end
      end
      if (dut_if.dut_res_valid && dut_if.dut_res_ready) begin
        check("sb_vec_idx_stable", 32'(vec_idx), 32'(mock_idx));
        sb_q.push_back('{pass: (int'(mock_idx) != corrupt_idx), idx: mock_idx});
        sb_due = 2;
      end
    end
  end

  task automatic check_idle(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_timeout_flag"}, timeout_flag, 0);
    check({pfx, "_pass_count"}, 32'(pass_count), 0);
    check({pfx, "_fail_count"}, 32'(fail_count), 0);
    check({pfx, "_last_fail_idx"}, 32'(last_fail_idx), 0);
    check({pfx, "_vec_idx"}, 32'(vec_idx), 0);
    check({pfx, "_req_valid"}, dut_if.dut_req_valid, 0);
    check({pfx, "_res_ready"}, dut_if.dut_res_ready, 0);
    check({pfx, "_state"}, 32'(dut.r_state), 32'(ST_IDLE));
  endtask

  // Called at a negedge; returns at the negedge just after the start edge.
  task automatic do_start(input logic lm);
    start     = 1'b1;
    loop_mode = lm;
    @(negedge clk);
    start     = 1'b0;
    loop_mode = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic wait_res_ready(input string tag);
    int n;
    n = 0;
    while (dut_if.dut_res_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, dut_if.dut_res_ready, 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   n;
    logic wrap_seen;
    logic [7:0] prev_idx;

    rst          = 1'b1;
    start        = 1'b0;
    loop_mode    = 1'b0;
    req_ready_en = 1'b1;
    hang_idx     = -1;
    corrupt_idx  = -1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean single pass: 4 vectors of 3 + 4 cycles each
    do_start(1'b0);
    check("t1_busy_after_start", busy, 1);
    check("t1_done_cleared", done, 0);
    wait_done(cyc);
    check("t1_latency_window", 32'((cyc + 1 >= 26) && (cyc + 1 <= 30)), 1);
    check("t1_pass_count", 32'(pass_count), 4);
    check("t1_fail_count", 32'(fail_count), 0);
    check("t1_timeout_flag", timeout_flag, 0);
    check("t1_busy_in_done", busy, 0);
    check("t1_req_valid_in_done", dut_if.dut_req_valid, 0);

    // Rerun from DONE with word 1 of vector 2 corrupted
    corrupt_idx = 2;
    do_start(1'b0);
    check("t2_pass_cleared", 32'(pass_count), 0);
    check("t2_fail_cleared", 32'(fail_count), 0);
    check("t2_done_cleared", done, 0);
    wait_done(cyc);
    check("t2_pass_count", 32'(pass_count), 3);
    check("t2_fail_count", 32'(fail_count), 1);
    check("t2_last_fail_idx", 32'(last_fail_idx), 2);
    corrupt_idx = -1;

    // start while a vector is outstanding must be ignored
    do_start(1'b0);
    n = 0;
    while (!(pass_count == 2 && dut_if.dut_res_ready === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_reached_wait_v2", dut_if.dut_res_ready, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_pass_unchanged", 32'(pass_count), 2);
    check("t3_vec_idx_unchanged", 32'(vec_idx), 2);
    wait_done(cyc);
    check("t3_pass_count", 32'(pass_count), 4);
    check("t3_fail_count", 32'(fail_count), 0);

    // Hung DUT on vector 1
    hang_idx = 1;
    do_start(1'b0);
    wait_done(cyc);
    check("t4_timeout_flag", timeout_flag, 1);
    check("t4_done", done, 1);
    check("t4_pass_count", 32'(pass_count), 1);
    check("t4_fail_count", 32'(fail_count), 1);
    check("t4_last_fail_idx", 32'(last_fail_idx), 1);
    check("t4_req_valid", dut_if.dut_req_valid, 0);
    check("t4_res_ready", dut_if.dut_res_ready, 0);
    hang_idx = -1;
    pulse_rst();
    check("t4_flag_cleared_by_rst", timeout_flag, 0);

    // Request held off for 10 cycles
    req_ready_en = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t5_req_valid_held", dut_if.dut_req_valid, 1);
      check("t5_timer_idle", 32'(dut.u_timer.r_count), 0);
      @(negedge clk);
    end
    req_ready_en = 1'b1;
    wait_done(cyc);
    check("t5_pass_count", 32'(pass_count), 4);

    // Reset in the middle of WAIT abandons the run
    do_start(1'b0);
    wait_res_ready("t6_reached_wait");
    rst = 1'b1;
    @(negedge clk);
    check_idle("t6_rst_mid_wait");
    rst = 1'b0;
    @(negedge clk);

    // Continuous loop: counters saturate, index wraps, busy never drops
    do_start(1'b1);
    wrap_seen = 1'b0;
    prev_idx  = vec_idx;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      check("t7_busy_in_loop", busy, 1);
      if (prev_idx == 8'd3 && vec_idx == 8'd0) wrap_seen = 1'b1;
      prev_idx = vec_idx;
    end
    check("t7_pass_saturated", 32'(pass_count), 15);
    check("t7_fail_count", 32'(fail_count), 0);
    check("t7_vec_idx_wrapped", wrap_seen, 1);
    check("t7_not_done", done, 0);
    pulse_rst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/selftest_runner.md
Name: selftest_runner

Overview:
- Parametrised on-chip self-test sequencer that drives the arithmetic cores (multmod, inv_montgomery, point_add, scalarmultB) through their req/res handshake.
- Steps through N_VEC test vectors and compares each DUT result against expected words from an external vector ROM.
- Keeps pass/fail counters, detects hung DUTs with a timeout, and supports single-pass or continuous-loop operation.
- Sits at board top level between the DUT instance and LED/test-point status outputs.

Parameters:
- W, 255, width of one result word.
- NOUT, 2, number of result words compared per vector (1 = scalar result, 2 = x/y point); 1..4.
- N_VEC, 4, number of vectors per pass; 1..256.
- TIMEOUT, 16777216, maximum cycles from request accept to result valid.
- CNT_W, 8, width of pass/fail counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- loop_mode  in  1  sampled on start; 1 = repeat passes until rst
- vec_idx  out  8  current vector index, drives the vector ROM and DUT operand mux
- exp_data  in  NOUT*W  expected result for vec_idx, word 0 in LSBs, combinational from the ROM
- dut_req_valid  out  1  request to DUT
- dut_req_ready  in  1  DUT accepts request
- dut_res_valid  in  1  DUT result available
- dut_res_ready  out  1  result consumed
- dut_res  in  NOUT*W  DUT result words, same packing as exp_data
- busy  out  1  run in progress
- done  out  1  run finished (single-pass) or aborted
- timeout_flag  out  1  sticky; DUT hung
- pass_count  out  CNT_W  vectors matched
- fail_count  out  CNT_W  vectors mismatched or timed out
- last_fail_idx  out  8  index of most recent failing vector

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timer 0. Reset mid-run drops dut_req_valid and dut_res_ready on the next edge and abandons the run. The DUT must share rst.
- States: IDLE, ISSUE, WAIT, CHECK, NEXT, DONE. busy = 1 in ISSUE, WAIT, CHECK and NEXT.
- IDLE/DONE, start=1: clear counters, timeout_flag, last_fail_idx and vec_idx; latch loop_mode; clear done; go to ISSUE. start in any other state is ignored.
- ISSUE: dut_req_valid=1 and held until dut_req_valid & dut_req_ready in the same cycle. On accept, go to WAIT and clear the timer.
- WAIT:
  - dut_res_ready=1; timer increments each cycle.
  - On dut_res_valid & dut_res_ready: register the compare result (all NOUT words equal exp_data) and go to CHECK.
  - If the timer reaches TIMEOUT-1 without a result: fail_count+1, last_fail_idx=vec_idx, timeout_flag=1, go to DONE. A timeout aborts the run even in loop mode.
  - If dut_res_valid and timeout fire in the same cycle, the result wins.
- CHECK (1 cycle): dut_res_ready=0. On match, pass_count+1; otherwise fail_count+1 and last_fail_idx=vec_idx. Counters saturate at all-ones and never wrap.
- NEXT (1 cycle):
  - If vec_idx != N_VEC-1: vec_idx+1, go to ISSUE.
  - Else if latched loop_mode: vec_idx=0, go to ISSUE.
  - Else go to DONE.
- DONE: done=1, held until the next start or rst.
- Latency: a clean vector costs DUT latency + 4 cycles (issue accept, capture, CHECK, NEXT). exp_data is sampled at capture, so the ROM must stay stable while vec_idx is constant.
- Only one request is ever outstanding; dut_req_valid is never asserted while in WAIT.

Decomposition:
- Shared package: the P25519 constant, the FSM state encoding, and the compare-word packing helper (word i occupies bits [i*W +: W]).
- One natural sub-module: selftest_timeout_ctr (clear, enable, TIMEOUT compare, expired pulse).
- The vector ROM stays outside so each top-level build selects its own vectors.

Test Plan:
- Mock DUT, fixed 3-cycle latency, N_VEC=4, all results correct, start pulse -> done after 4*(3+4) cycles ±2; pass_count=4, fail_count=0, timeout_flag=0.
- Vector 2 returns word1 flipped in bit 0 -> pass_count=3, fail_count=1, last_fail_idx=2.
- Mock DUT never asserts res_valid on vector 1, TIMEOUT=16 -> timeout_flag=1, done=1, fail_count=1, last_fail_idx=1, dut_req_valid=0.
- loop_mode=1 with CNT_W=4, all pass -> pass_count saturates at 15, busy stays 1, vec_idx wraps 3→0.
- dut_req_ready held low for 10 cycles -> dut_req_valid stays high throughout and the timer stays 0 until accept; rst asserted mid-WAIT -> next cycle all outputs 0 and state IDLE.
- start pulsed during WAIT is ignored (counters unchanged); start in DONE clears counters and reruns.
